fcb_weight_load_sched: RTL and testbench

- Sequences the FC-B layer around its weight/bias memories.
- Accepts a RISC-V write stream (valid/ready), decodes each address into one-hot weight-memory or bias-memory write enables, and counts loaded words.
- Releases the layer start handshake from the previous layer only once the full parameter set is resident.
- Blocks parameter writes while the FC datapath is computing. Sits between the RISC-V bus and the FC-B top (riscv_data, riscv_address, wm_enable_write, bm_enable_write, start_from_previous).

---
 rtl/fcb_weight_load_sched_pkg.sv | 28 ++
 rtl/fcb_weight_load_sched_if.sv | 17 +
 rtl/fcb_addr_decode.sv | 37 +++
 rtl/fcb_weight_load_sched.sv | 169 ++++++++++++++++
 tb/tb_fcb_weight_load_sched.sv | 280 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fcb_weight_load_sched_pkg.sv
// Shared definitions for the FC-B weight/bias load scheduler: FSM states,
// default geometry and the derived word-count helpers.
package fcb_weight_load_sched_pkg;

    typedef enum logic [1:0] {
        StLoad  = 2'd0,
        StArmed = 2'd1,
        StRun   = 2'd2
    } sched_state_e;

    localparam int unsigned DEF_DATA_WIDTH   = 32;
    localparam int unsigned DEF_ADDRESS_BITS = 15;
    localparam int unsigned DEF_IFM_DEPTH    = 84;
    // Number of weight memories; the same value is the select code of the bias memory.
    localparam int unsigned DEF_NUMBER_OF_WM = 10;

    // One word per (memory, input) pair plus one bias word per memory.
    function automatic int unsigned total_words(input int unsigned n_wm,
                                                input int unsigned depth);
        return n_wm * depth + n_wm;
    endfunction

    // Width of a counter that must reach total inclusive.
    function automatic int unsigned count_width(input int unsigned total);
        return $clog2(total + 1);
    endfunction

endpackage

// File: rtl/fcb_weight_load_sched_if.sv
// RISC-V parameter write channel (valid/ready) into the load scheduler.
interface fcb_weight_load_sched_if
    import fcb_weight_load_sched_pkg::*;
#(
    parameter int unsigned DATA_WIDTH   = DEF_DATA_WIDTH,
    parameter int unsigned ADDRESS_BITS = DEF_ADDRESS_BITS
) ();

    logic                    valid;
    logic                    ready;
    logic [DATA_WIDTH-1:0]   data;
    logic [ADDRESS_BITS-1:0] address;

    modport master (output valid, output data, output address, input ready);
    modport slave  (input valid, input data, input address, output ready);

endinterface

// File: rtl/fcb_addr_decode.sv
// Combinational address map for FC weight/bias memories: upper field selects
// the memory, lower field is the word index inside it.
module fcb_addr_decode
    import fcb_weight_load_sched_pkg::*;
#(
    parameter int unsigned ADDRESS_BITS    = DEF_ADDRESS_BITS,
    parameter int unsigned IFM_DEPTH       = DEF_IFM_DEPTH,
    parameter int unsigned NUMBER_OF_WM    = DEF_NUMBER_OF_WM,
    parameter int unsigned ADDRESS_SIZE_WM = $clog2(IFM_DEPTH)
) (
    input  logic [ADDRESS_BITS-1:0] address,
    output logic [NUMBER_OF_WM-1:0] wm_onehot,
    output logic                    bm_hit,
    output logic                    valid
);

    localparam int unsigned SEL_W = ADDRESS_BITS - ADDRESS_SIZE_WM;

    logic [ADDRESS_SIZE_WM-1:0] idx;
    logic [SEL_W-1:0]           sel;
    logic                       wm_hit;

    assign idx = address[ADDRESS_SIZE_WM-1:0];
    assign sel = address[ADDRESS_BITS-1:ADDRESS_SIZE_WM];

    // Classify as weight word, bias word (select == NUMBER_OF_WM) or out of map
    always_comb begin
        wm_onehot = '0;
        wm_hit    = (32'(sel) < NUMBER_OF_WM) && (32'(idx) < IFM_DEPTH);
        bm_hit    = (32'(sel) == NUMBER_OF_WM) && (32'(idx) < NUMBER_OF_WM);
        valid     = wm_hit | bm_hit;
        for (int unsigned i = 0; i < NUMBER_OF_WM; i++) begin
            wm_onehot[i] = wm_hit && (32'(sel) == i);
        end
    end

endmodule

// File: rtl/fcb_weight_load_sched.sv
// FC-B weight load scheduler: turns RISC-V writes into memory write pulses,
// counts resident words and holds the layer start until the set is complete.
module fcb_weight_load_sched
    import fcb_weight_load_sched_pkg::*;
#(
    parameter int unsigned DATA_WIDTH      = DEF_DATA_WIDTH,
    parameter int unsigned ADDRESS_BITS    = DEF_ADDRESS_BITS,
    parameter int unsigned IFM_DEPTH       = DEF_IFM_DEPTH,
    parameter int unsigned NUMBER_OF_WM    = DEF_NUMBER_OF_WM,
    parameter int unsigned ADDRESS_SIZE_WM = $clog2(IFM_DEPTH),
    parameter int unsigned TOTAL_WORDS     = total_words(NUMBER_OF_WM, IFM_DEPTH),
    localparam int unsigned CNT_W          = count_width(TOTAL_WORDS)
) (
    input  logic                     clk,
    input  logic                     reset,
    fcb_weight_load_sched_if.slave   cfg,
    input  logic                     reload,
    output logic [DATA_WIDTH-1:0]    riscv_data,
    output logic [ADDRESS_BITS-1:0]  riscv_address,
    output logic [NUMBER_OF_WM-1:0]  wm_enable_write,
    output logic                     bm_enable_write,
    input  logic                     start_from_previous,
    output logic                     start_to_fc,
    input  logic                     fc_output_ready,
    output logic                     load_done,
    output logic                     addr_error,
    output logic [CNT_W-1:0]         words_loaded
);

    localparam logic [CNT_W-1:0] FULL = CNT_W'(TOTAL_WORDS);

    sched_state_e               state_q, state_d;
    logic [CNT_W-1:0]           count_q, count_d;
    logic                       pending_start_q, pending_start_d;
    logic                       pending_reload_q, pending_reload_d;
    logic                       addr_error_q, addr_error_d;
    logic [DATA_WIDTH-1:0]      data_q;
    logic [ADDRESS_BITS-1:0]    addr_q;
    logic [NUMBER_OF_WM-1:0]    wm_en_q;
    logic                       bm_en_q;
    logic [NUMBER_OF_WM-1:0]    dec_wm;
    logic                       dec_bm;
    logic                       dec_valid;
    logic                       ready;
    logic                       accept;
    logic [ADDRESS_SIZE_WM-1:0] word_idx;

    fcb_addr_decode #(
        .ADDRESS_BITS    (ADDRESS_BITS),
        .IFM_DEPTH       (IFM_DEPTH),
        .NUMBER_OF_WM    (NUMBER_OF_WM),
        .ADDRESS_SIZE_WM (ADDRESS_SIZE_WM)
    ) u_decode (
        .address   (cfg.address),
        .wm_onehot (dec_wm),
        .bm_hit    (dec_bm),
        .valid     (dec_valid)
    );

    // Writes are refused only while the datapath is computing
    assign ready     = (state_q != StRun);
    assign cfg.ready = ready;
    assign accept    = cfg.valid & ready;
    assign word_idx  = cfg.address[ADDRESS_SIZE_WM-1:0];

    // Next-state, load counting and start gating
    always_comb begin
        state_d          = state_q;
        count_d          = count_q;
        pending_start_d  = pending_start_q;
        pending_reload_d = pending_reload_q;
        addr_error_d     = addr_error_q;
        start_to_fc      = 1'b0;

        if (accept && !dec_valid) begin
            addr_error_d = 1'b1;
        end
        // Overwrites count too; saturate so load_done can never wrap
        if (accept && dec_valid && count_q != FULL) begin
            count_d = count_q + CNT_W'(1);
        end
        // Starts outside ARMED are remembered; repeats collapse into one
        if (start_from_previous) begin
            pending_start_d = 1'b1;
        end

        case (state_q)
            StLoad: begin
                if (reload) begin
                    count_d      = '0;
                    addr_error_d = 1'b0;
                end else if (count_d == FULL) begin
                    state_d = StArmed;
                end
            end
            StArmed: begin
                if (reload) begin
                    count_d      = '0;
                    addr_error_d = 1'b0;
                    state_d      = StLoad;
                end else if (start_from_previous || pending_start_q) begin
                    start_to_fc     = 1'b1;
                    pending_start_d = 1'b0;
                    state_d         = StRun;
                end
            end
            StRun: begin
                // A reload cannot disturb the running layer; defer it
                if (reload) begin
                    pending_reload_d = 1'b1;
                end
                if (fc_output_ready) begin
                    if (reload || pending_reload_q) begin
                        state_d          = StLoad;
                        count_d          = '0;
                        addr_error_d     = 1'b0;
                        pending_reload_d = 1'b0;
                    end else begin
                        state_d = StArmed;
                    end
                end
            end
            default: state_d = StLoad;
        endcase
    end

    // Scheduler state registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q          <= StLoad;
            count_q          <= '0;
            pending_start_q  <= 1'b0;
            pending_reload_q <= 1'b0;
            addr_error_q     <= 1'b0;
        end else begin
            state_q          <= state_d;
            count_q          <= count_d;
            pending_start_q  <= pending_start_d;
            pending_reload_q <= pending_reload_d;
            addr_error_q     <= addr_error_d;
        end
    end

    // Memory-side write port: one-cycle enables, data/index held between writes
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wm_en_q <= '0;
            bm_en_q <= 1'b0;
            data_q  <= '0;
            addr_q  <= '0;
        end else begin
            wm_en_q <= accept ? dec_wm : '0;
            bm_en_q <= accept & dec_bm;
            if (accept && dec_valid) begin
                data_q <= cfg.data;
                addr_q <= ADDRESS_BITS'(word_idx);
            end
        end
    end

    assign riscv_data      = data_q;
    assign riscv_address   = addr_q;
    assign wm_enable_write = wm_en_q;
    assign bm_enable_write = bm_en_q;
    assign load_done       = (state_q != StLoad);
    assign addr_error      = addr_error_q;
    assign words_loaded    = count_q;

endmodule

// File: tb/tb_fcb_weight_load_sched.sv
// Self-checking bench for fcb_weight_load_sched: directed scenarios with
// randomized data/gaps, checked every cycle against a rule-level model.
module tb_fcb_weight_load_sched;

    localparam int DW    = 32;
    localparam int AB    = 15;
    localparam int NWM   = 10;
    localparam int DEPTH = 84;
    localparam int TOTAL = 850;
    localparam int SPAN  = 128;  // address stride between memories

    logic           clk;
    logic           rst;
    logic           reload;
    logic           start_from_previous;
    logic           fc_output_ready;
    logic           start_to_fc;
    logic           bm_enable_write;
    logic           load_done;
    logic           addr_error;
    logic [DW-1:0]  riscv_data;
    logic [AB-1:0]  riscv_address;
    logic [NWM-1:0] wm_enable_write;
    logic [9:0]     words_loaded;

    fcb_weight_load_sched_if #(.DATA_WIDTH(DW), .ADDRESS_BITS(AB)) cfg_bus ();

    fcb_weight_load_sched dut (
        .clk                 (clk),
        .reset               (rst),
        .cfg                 (cfg_bus),
        .reload              (reload),
        .riscv_data          (riscv_data),
        .riscv_address       (riscv_address),
        .wm_enable_write     (wm_enable_write),
        .bm_enable_write     (bm_enable_write),
        .start_from_previous (start_from_previous),
        .start_to_fc         (start_to_fc),
        .fc_output_ready     (fc_output_ready),
        .load_done           (load_done),
        .addr_error          (addr_error),
        .words_loaded        (words_loaded)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec;
    int n_miss;

    // Reference model: phase 0 loading, 1 armed, 2 running
    int             m_phase;
    int             m_count;
    bit             m_err;
    bit             m_ps;
    bit             m_pr;
    bit             m_bm;
    logic [NWM-1:0] m_wm;
    logic [DW-1:0]  m_data;
    int             m_addr;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_miss++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_phase = 0; m_count = 0; m_err = 0; m_ps = 0; m_pr = 0;
        m_bm = 0; m_wm = '0; m_data = '0; m_addr = 0;
    endtask

    task automatic check_regs();
        chk("load_done", load_done, m_phase != 0);
        chk("words_loaded", words_loaded, m_count);
        chk("addr_error", addr_error, m_err);
        chk("wm_enable_write", wm_enable_write, m_wm);
        chk("bm_enable_write", bm_enable_write, m_bm);
        chk("riscv_data", riscv_data, m_data);
        chk("riscv_address", riscv_address, m_addr);
    endtask

    // 0 weight word, 1 bias word, 2 outside the map
    function automatic int kind_of(input logic [AB-1:0] a);
        int sel = int'(a) / SPAN;
        int idx = int'(a) % SPAN;
        if (sel < NWM && idx < DEPTH) return 0;
        if (sel == NWM && idx < NWM) return 1;
        return 2;
    endfunction

    // Word w of the parameter set in load order: weights then biases
    function automatic logic [AB-1:0] addr_of(input int w);
        if (w < NWM * DEPTH) return AB'((w / DEPTH) * SPAN + (w % DEPTH));
        return AB'(NWM * SPAN + (w - NWM * DEPTH));
    endfunction

    function automatic logic [AB-1:0] bad_addr();
        int sel;
        int idx;
        case ($urandom_range(0, 2))
            0: begin sel = $urandom_range(11, 255); idx = $urandom_range(0, 127); end
            1: begin sel = $urandom_range(0, 9); idx = $urandom_range(84, 127); end
            default: begin sel = NWM; idx = $urandom_range(10, 127); end
        endcase
        return AB'(sel * SPAN + idx);
    endfunction

    // One clock: drive at negedge, check, advance model, return at posedge+1
    task automatic cycle(input bit v, input logic [AB-1:0] a, input logic [DW-1:0] d,
                         input bit rl, input bit sfp, input bit fcr);
        bit exp_ready;
        bit exp_start;
        bit acc;
        int k;
        @(negedge clk);
        cfg_bus.valid = v; cfg_bus.address = a; cfg_bus.data = d;
        reload = rl; start_from_previous = sfp; fc_output_ready = fcr;
        #1;
        k = kind_of(a);
        exp_ready = (m_phase != 2);
        exp_start = (m_phase == 1) && !rl && (sfp || m_ps);
        acc = v && exp_ready;
        check_regs();
        chk("cfg_ready", cfg_bus.ready, exp_ready);
        chk("start_to_fc", start_to_fc, exp_start);
        m_wm = '0;
        if (acc && k == 0) m_wm[int'(a) / SPAN] = 1'b1;
        m_bm = acc && (k == 1);
        if (acc && k != 2) begin
            m_data = d;
            m_addr = int'(a) % SPAN;
        end
        if (m_phase == 2) begin
            if (sfp) m_ps = 1;
            if (rl) m_pr = 1;
            if (fcr) begin
                if (m_pr) begin
                    m_phase = 0; m_count = 0; m_err = 0; m_pr = 0;
                end else begin
                    m_phase = 1;
                end
            end
        end else if (rl) begin
            m_phase = 0; m_count = 0; m_err = 0;
            if (sfp) m_ps = 1;
        end else begin
            if (acc && k == 2) m_err = 1;
            if (acc && k != 2 && m_count < TOTAL) m_count++;
            if (exp_start) begin
                m_ps = 0; m_phase = 2;
            end else begin
                if (sfp) m_ps = 1;
                if (m_phase == 0 && m_count == TOTAL) m_phase = 1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_vec = 0;
        n_miss = 0;
        rst = 1'b1;
        reload = 0; start_from_previous = 0; fc_output_ready = 0;
        cfg_bus.valid = 0; cfg_bus.address = '0; cfg_bus.data = '0;
        model_reset();
        #1;
        check_regs();
        chk("reset_cfg_ready", cfg_bus.ready, 1'b1);
        chk("reset_start_to_fc", start_to_fc, 1'b0);
        @(negedge clk);
        rst = 1'b0;

        // Single writes: weight, bias, two out-of-map addresses
        cycle(1, 15'h0053, $urandom, 0, 0, 0);
        chk("wm_0x0053", wm_enable_write, 10'b0000000001);
        chk("addr_0x0053", riscv_address, 83);
        cycle(0, '0, '0, 0, 0, 0);
        chk("wm_pulse_one_cycle", wm_enable_write, 0);
        cycle(1, 15'(10 * SPAN + 9), $urandom, 0, 0, 0);
        chk("bm_sel10_idx9", bm_enable_write, 1);
        cycle(1, 15'(11 * SPAN), $urandom, 0, 0, 0);
        chk("err_sel11", addr_error, 1);
        chk("sel11_no_enable", wm_enable_write, 0);
        cycle(1, 15'(84), $urandom, 0, 0, 0);
        chk("idx84_not_counted", words_loaded, 2);
        chk("idx84_no_enable", wm_enable_write, 0);
        cycle(0, '0, '0, 1, 0, 0);
        chk("reload_clears_err", addr_error, 0);
        chk("reload_clears_count", words_loaded, 0);

        // Full in-order load with random gaps/bad writes; starts at words 400 and 600
        for (int w = 0; w < TOTAL; w++) begin
            if ($urandom_range(0, 3) == 0) cycle(1, bad_addr(), $urandom, 0, 0, 0);
            if ($urandom_range(0, 3) == 0) cycle(0, '0, '0, 0, 0, 0);
            cycle(1, addr_of(w), $urandom, 0, (w == 400 || w == 600), 0);
            if (w == TOTAL - 2) begin
                chk("done_low_before_last", load_done, 0);
                chk("no_early_start", start_to_fc, 0);
            end
        end
        chk("count_full", words_loaded, TOTAL);
        chk("done_after_last", load_done, 1);
        chk("start_on_arm", start_to_fc, 1);
        cycle(0, '0, '0, 0, 0, 0);
        chk("ready_low_in_run", cfg_bus.ready, 0);

        // Held write during RUN is accepted once the layer finishes
        for (int i = 0; i < 5; i++) cycle(1, addr_of(7), 32'hA5A5_0007, 0, 0, 0);
        cycle(1, addr_of(7), 32'hA5A5_0007, 0, 0, 1);
        chk("ready_after_fc", cfg_bus.ready, 1);
        cycle(1, addr_of(7), 32'hA5A5_0007, 0, 0, 0);
        chk("held_write_en", wm_enable_write, 10'b0000000001);
        chk("held_write_data", riscv_data, 32'hA5A5_0007);

        // Start in ARMED, then finish+start together, then deferred reload
        cycle(0, '0, '0, 0, 1, 0);
        cycle(0, '0, '0, 0, 1, 1);
        chk("pending_start_fires", start_to_fc, 1);
        cycle(0, '0, '0, 0, 0, 0);
        cycle(0, '0, '0, 1, 0, 0);
        chk("reload_in_run_done_held", load_done, 1);
        cycle(0, '0, '0, 0, 1, 0);
        cycle(0, '0, '0, 0, 0, 0);
        cycle(0, '0, '0, 0, 0, 1);
        chk("deferred_reload_done", load_done, 0);
        chk("deferred_reload_count", words_loaded, 0);

        // Reload pass with random addresses; the remembered start must wait
        for (int w = 0; w < TOTAL; w++) begin
            if ($urandom_range(0, 4) == 0) cycle(0, '0, '0, 0, 0, 0);
            cycle(1, addr_of($urandom_range(0, TOTAL - 1)), $urandom, 0, 0, 0);
        end
        chk("reload_start_on_arm", start_to_fc, 1);
        cycle(0, '0, '0, 0, 0, 0);
        cycle(0, '0, '0, 0, 0, 1);
        cycle(0, '0, '0, 1, 0, 0);
        chk("armed_reload_done", load_done, 0);
        cycle(1, addr_of(1), $urandom, 0, 0, 0);
        cycle(1, addr_of(3), $urandom, 1, 0, 0);
        chk("reload_write_issued", wm_enable_write, 10'b0000000001);
        chk("reload_write_uncounted", words_loaded, 0);

        // Asynchronous reset with a write enable in flight
        for (int w = 0; w <= 123; w++) cycle(1, addr_of(w), $urandom, 0, 0, 0);
        chk("en_before_reset", wm_enable_write, 10'b0000000010);
        rst = 1'b1;
        #1;
        chk("rst_kills_wm", wm_enable_write, 0);
        chk("rst_kills_bm", bm_enable_write, 0);
        chk("rst_count", words_loaded, 0);
        chk("rst_done", load_done, 0);
        chk("rst_ready", cfg_bus.ready, 1);
        model_reset();
        @(negedge clk);
        cfg_bus.valid = 0; reload = 0; start_from_previous = 0; fc_output_ready = 0;
        rst = 1'b0;

        // Fully random traffic
        for (int i = 0; i < 300; i++) begin
            cycle($urandom_range(0, 1) == 1,
                  AB'($urandom_range(0, 12) * SPAN + $urandom_range(0, 127)),
                  $urandom, $urandom_range(0, 30) == 0,
                  $urandom_range(0, 9) == 0, $urandom_range(0, 7) == 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
